kbd_event_queue: RTL
====================

// Module: kbd_event_queue
// PURPOSE
//  Buffers keyboard characters from ps2_decoder in a small FIFO and exposes them on the CPU bus.
//  Provides a data register that pops on read and a status/control register.
//  Drives the single-source interrupt request (interrupt_vector/interrupt_ack) to riscv64.
//  Sits between ps2_decoder (upstream) and the bus read multiplexer (downstream) in cpu_on_board.
// PARAMETERS
//  DEPTH      8           FIFO entries; power of 2, minimum 2
//  KEY_BASE   `Key_base   byte address of DATA register; STATUS is at KEY_BASE+8
//  IRQ_VEC    4'd1        vector value driven while the interrupt is pending
// PORTS
//  clk               in   1   system clock (CLOCK_50 domain)
//  reset             in   1   asynchronous, active-high reset
//  key_pressed       in   1   level from ps2_decoder; high while a key is held
//  ascii_code        in   8   ASCII code from ps2_decoder; valid while key_pressed is high
//  bus_address       in   64  CPU bus address
//  bus_read_enable   in   1   CPU read strobe; level, may be held many clk cycles
//  bus_write_enable  in   1   CPU write strobe; level
//  bus_write_data    in   64  CPU write data
//  bus_read_data     out  64  registered read data
//  rd_hit            out  1   registered; high when bus_read_data is driven by this block
//  interrupt_vector  out  4   IRQ_VEC when pending, otherwise 0
//  interrupt_ack     in   1   CPU acknowledge; level
//  overflow          out  1   sticky flag; set when a character is dropped
//  count             out  4   current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async): FIFO empty, count=0, overflow=0, bus_read_data=0, rd_hit=0, interrupt_vector=0, irq state IDLE.
//  Push:
//   - A push fires on the rising edge of key_pressed (registered delay) when ascii_code != 0.
//   - ascii_code == 0 is ignored.
//  Address decode:
//   - sel_d = (bus_address == KEY_BASE).
//   - sel_s = (bus_address == KEY_BASE+8).
//  Pop:
//   - A pop fires on the rising edge of (bus_read_enable & sel_d) while the FIFO is non-empty.
//   - Exactly one pop per read strobe, however long the strobe is held.
//  Read data, latency 1 clk from any clk with bus_read_enable & (sel_d|sel_s):
//   - DATA:   {56'd0, head}, captured in the same edge as the pop; 0 if the FIFO is empty.
//   - STATUS: {56'd0, count[3:0], 2'b0, overflow, ~empty}.
//   - rd_hit=1 on those cycles, else 0.
//   - bus_read_data holds its last value when not selected.
//  Write:
//   - bus_write_enable & sel_s & bus_write_data[1] clears overflow.
//   - bus_write_enable & sel_s & bus_write_data[2] flushes the FIFO (count=0). Flush takes priority over a same-cycle push.
//   - Writes to DATA are ignored.
//  Full/empty:
//   - Push while full with no same-cycle pop: data dropped, overflow<=1.
//   - Push + pop in the same cycle: both take effect, count unchanged, no overflow even if full.
//   - Pop while empty: no effect, pointers unchanged.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - count is log2(DEPTH)+1 bits, zero-extended to 4 bits.
//  IRQ FSM:
//   - IDLE -> PENDING when count != 0; interrupt_vector <= IRQ_VEC.
//   - PENDING -> SERVICE when interrupt_ack == 1; interrupt_vector <= 0.
//   - SERVICE -> IDLE on the next pop or flush.
//   - From IDLE, the interrupt re-raises one clk later if characters remain.
//   - ack while IDLE or SERVICE is ignored.
//   - Reset in any state returns to IDLE with vector 0. FIFO contents are lost.
// STRUCTURE
//  Shared header.vh: `Key_base (existing); add `Key_stat = `Key_base+8 and status bit indices.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push, pop, flush, dout (head), full, empty, count.
//  Top of this block contains:
//   - edge detectors for key_pressed and the read strobe;
//   - address decode and the registered read mux;
//   - the overflow flag;
//   - the 3-state IRQ FSM.
// TESTING
//  Reset asserted mid-burst with 3 entries queued -> count=0, interrupt_vector=0, next DATA read returns 0.
//  Press 'a' (0x61) -> vector=1 within 2 clk; ack -> vector=0;
//   hold DATA read 20 clk -> returns 0x61 once, count goes 1->0, vector stays 0.
//  Push 9 keys with DEPTH=8 -> overflow=1, count=8, reads return the first 8 codes in order;
//   STATUS write 0x2 -> overflow=0.
//  FIFO full, key edge and DATA-read edge in the same clk -> count stays 8, overflow=0, order preserved.
//  Two keys queued, ack, then one pop -> FSM returns to IDLE, vector=1 again after 1 clk.
//  STATUS read with 3 queued -> 0x31; STATUS write 0x4 -> count=0, vector=0 after SERVICE->IDLE.

Source files
------------

// File: rtl/kbd_event_queue_pkg.sv
// Shared definitions for the keyboard event queue: register map, control
// bit positions, IRQ state encoding and the STATUS word packer.
package kbd_event_queue_pkg;

  // Byte address of the DATA register; STATUS sits one 64-bit word above it.
  localparam logic [63:0] KEY_BASE_DEFAULT = 64'h0000_0000_1000_0100;
  localparam logic [63:0] KEY_STAT_OFFSET  = 64'd8;

  // STATUS write control bits.
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_FLUSH_BIT   = 2;

  // Interrupt request state. The encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // STATUS layout: [7:4] occupancy, [1] sticky overflow, [0] data available.
  function automatic logic [63:0] status_word(input logic [3:0] cnt,
                                              input logic       ovf,
                                              input logic       not_empty);
    return {56'd0, cnt, 2'b00, ovf, not_empty};
  endfunction

endpackage

// File: rtl/kbd_event_queue_sync_fifo.sv
// Small synchronous FIFO holding keyboard codes. Flush wins over push and pop.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is dropped (the caller tracks overflow).
module kbd_event_queue_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  // Next pointer and occupancy; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Keyboard event queue: buffers ps2_decoder codes, exposes DATA (pop on read)
// and STATUS/control registers on the CPU bus, and raises a single interrupt.
// Handshake: a character enters on each rising edge of key_pressed with a
// non-zero code; it leaves on each rising edge of a DATA read strobe, so a
// strobe held for many cycles pops exactly once.
module kbd_event_queue
  import kbd_event_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [63:0] KEY_BASE = KEY_BASE_DEFAULT,
  parameter logic [3:0]  IRQ_VEC  = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_pressed,
  input  logic [7:0]  ascii_code,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [63:0] bus_write_data,
  output logic [63:0] bus_read_data,
  output logic        rd_hit,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  output logic        overflow,
  output logic [3:0]  count,
  output logic [1:0]  irq_state_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_q, rd_q;
  logic          sel_d, sel_s;
  logic          rd_data_sel, rd_stat_sel, wr_stat;
  logic          push, pop, flush, clr_ovf, ovf_set;
  logic [7:0]    head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;
  logic          overflow_q, overflow_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          hit_q, hit_d;
  irq_state_e    state_q, state_d;
  logic [3:0]    vec_q, vec_d;
  logic          unused_wdata;

  assign sel_d       = (bus_address == KEY_BASE);
  assign sel_s       = (bus_address == (KEY_BASE + KEY_STAT_OFFSET));
  assign rd_data_sel = bus_read_enable & sel_d;
  assign rd_stat_sel = bus_read_enable & sel_s;
  assign wr_stat     = bus_write_enable & sel_s;

  assign push    = key_pressed & ~key_q & (ascii_code != 8'd0);
  assign pop     = rd_data_sel & ~rd_q & ~fifo_empty;
  assign flush   = wr_stat & bus_write_data[CTRL_FLUSH_BIT];
  assign clr_ovf = wr_stat & bus_write_data[CTRL_CLR_OVF_BIT];
  // A push into a full FIFO is lost unless a pop makes room; a flush
  // discards it deliberately, which is not an overflow.
  assign ovf_set = push & fifo_full & ~pop & ~flush;

  assign count4       = 4'(fifo_count);
  assign unused_wdata = ^{bus_write_data[63:3], bus_write_data[0]};

  kbd_event_queue_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (ascii_code),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Delayed copies of key_pressed and the DATA read strobe for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      key_q <= key_pressed;
      rd_q  <= rd_data_sel;
    end
  end

  // Sticky overflow: a new drop wins over a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
  end

  // Registered read mux; DATA shows the head as it was before this edge's pop.
  always_comb begin
    rdata_d = rdata_q;
    hit_d   = 1'b0;
    if (rd_data_sel) begin
      hit_d   = 1'b1;
      rdata_d = fifo_empty ? 64'd0 : {56'd0, head};
    end else if (rd_stat_sel) begin
      hit_d   = 1'b1;
      rdata_d = status_word(count4, overflow_q, ~fifo_empty);
    end
  end

  // IRQ next state: raise when data waits, drop on ack, rearm after a pop/flush.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IRQ_IDLE: begin
        if (fifo_count != '0) begin
          state_d = IRQ_PENDING;
          vec_d   = IRQ_VEC;
        end
      end
      IRQ_PENDING: begin
        if (interrupt_ack) begin
          state_d = IRQ_SERVICE;
          vec_d   = 4'd0;
        end
      end
      IRQ_SERVICE: begin
        if (pop || flush) state_d = IRQ_IDLE;
      end
      default: begin
        state_d = IRQ_IDLE;
        vec_d   = 4'd0;
      end
    endcase
  end

  // Bus-facing, overflow and IRQ registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      rdata_q    <= 64'd0;
      hit_q      <= 1'b0;
      state_q    <= IRQ_IDLE;
      vec_q      <= 4'd0;
    end else begin
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
    end
  end

  assign bus_read_data    = rdata_q;
  assign rd_hit           = hit_q;
  assign overflow         = overflow_q;
  assign count            = count4;
  assign interrupt_vector = vec_q;
  assign irq_state_o      = state_q;

endmodule
